hazard_scoreboard: RTL

- Clocked, parametrised hazard detection unit for the 5-stage RISC-V pipeline.
- Tracks in-flight destination registers with per-register writer counters, not tag matching.
- Holds decode on RAW dependences and on WAW counter saturation.
- Runs a control-hazard FSM that holds fetch from branch/jump issue until resolution, then flushes on taken.

---
 rtl/hazard_scoreboard.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard detection for the 5-stage RISC-V pipeline: per-register writer counters
// for RAW/WAW stalls plus a control-hazard FSM. HAZARD_SCOREBOARD_PERF_EN adds perf counters.
module hazard_scoreboard #(
    parameter int NREG         = 32,
    parameter int REG_AW       = 5,
    parameter int MAX_INFLIGHT = 3,
    parameter int RF_BYPASS    = 1,
    localparam int CW          = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [31:0]       id_inst,
    input  logic              issue,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              br_resolve,
    input  logic              br_taken,
    output logic              stall_data,
    output logic              stall_ctrl,
    output logic              flush_id,
    output logic [NREG-1:0]   busy_mask,
    output logic [REG_AW-1:0] hazard_rd
`ifdef HAZARD_SCOREBOARD_PERF_EN
    ,
    output logic [31:0]       perf_data_stalls,
    output logic [31:0]       perf_ctrl_stalls,
    output logic [31:0]       perf_flushes
`endif
);

    typedef enum logic {RUN, WAIT} state_e;

    state_e                  state_q, state_d;
    logic                    flush_q, flush_d;
    logic [NREG-1:0][CW-1:0] cnt_q, cnt_d;

    logic [6:0]        opc;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic              use_rs1, use_rs2, has_rd, is_ctrl;
    logic [CW-1:0]     c_rs1, c_rs2, c_rd;
    logic              pend_rs1, pend_rs2, sat_rd, accept;

    assign opc = id_inst[6:0];
    assign rs1 = REG_AW'(id_inst[19:15]);
    assign rs2 = REG_AW'(id_inst[24:20]);
    assign rd  = REG_AW'(id_inst[11:7]);

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        has_rd  = 1'b0;
        case (opc)
            7'b0110011:                         begin use_rs1 = 1'b1; use_rs2 = 1'b1; has_rd = 1'b1; end
            7'b0010011, 7'b0000011, 7'b1100111: begin use_rs1 = 1'b1; has_rd = 1'b1; end
            7'b0100011, 7'b1100011:             begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
            7'b0110111, 7'b0010111, 7'b1101111: has_rd = 1'b1;
            default: ;
        endcase
    end

    assign is_ctrl = (opc == 7'b1100011) || (opc == 7'b1101111) || (opc == 7'b1100111);

    // Explicit lookup so NREG < 2**REG_AW reads as an idle register, not out of range.
    always_comb begin
        c_rs1 = '0;
        c_rs2 = '0;
        c_rd  = '0;
        for (int r = 1; r < NREG; r++) begin
            if (rs1 == REG_AW'(r)) c_rs1 = cnt_q[r];
            if (rs2 == REG_AW'(r)) c_rs2 = cnt_q[r];
            if (rd  == REG_AW'(r)) c_rd  = cnt_q[r];
        end
    end

    // A last outstanding writer retiring this cycle is forwarded by the write-through RF.
    always_comb begin
        pend_rs1 = use_rs1 && (c_rs1 != '0) &&
                   !((RF_BYPASS != 0) && wb_en && (wb_rd == rs1) && (c_rs1 == CW'(1)));
        pend_rs2 = use_rs2 && (c_rs2 != '0) &&
                   !((RF_BYPASS != 0) && wb_en && (wb_rd == rs2) && (c_rs2 == CW'(1)));
        sat_rd   = has_rd && (rd != '0) && (c_rd == CW'(MAX_INFLIGHT));
    end

    assign stall_data = id_valid && (pend_rs1 || pend_rs2 || sat_rd);
    assign stall_ctrl = (state_q == WAIT);
    assign accept     = issue && id_valid && !stall_data && !stall_ctrl;
    assign flush_id   = flush_q;

    always_comb begin
        hazard_rd = '0;
        if (id_valid) begin
            if (pend_rs1)      hazard_rd = rs1;
            else if (pend_rs2) hazard_rd = rs2;
            else if (sat_rd)   hazard_rd = rd;
        end
    end

    always_comb begin
        logic inc, dec;
        cnt_d = cnt_q;
        for (int r = 0; r < NREG; r++) begin
            inc = accept && has_rd && (rd != '0) && (rd == REG_AW'(r));
            dec = wb_en && (wb_rd != '0) && (wb_rd == REG_AW'(r)) && (cnt_q[r] != '0);
            if (inc && !dec)      cnt_d[r] = cnt_q[r] + CW'(1);
            else if (dec && !inc) cnt_d[r] = cnt_q[r] - CW'(1);
        end
        busy_mask = '0;
        for (int r = 0; r < NREG; r++) busy_mask[r] = (cnt_q[r] != '0);
    end

    always_comb begin
        state_d = state_q;
        flush_d = 1'b0;
        case (state_q)
            RUN:  if (accept && is_ctrl) state_d = WAIT;
            WAIT: if (br_resolve) begin
                      state_d = RUN;
                      flush_d = br_taken;
                  end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            flush_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic [31:0] pdata_q, pctrl_q, pflush_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pdata_q  <= '0;
            pctrl_q  <= '0;
            pflush_q <= '0;
        end else begin
            if (stall_data && (pdata_q  != 32'hFFFF_FFFF)) pdata_q  <= pdata_q  + 32'd1;
            if (stall_ctrl && (pctrl_q  != 32'hFFFF_FFFF)) pctrl_q  <= pctrl_q  + 32'd1;
            if (flush_id   && (pflush_q != 32'hFFFF_FFFF)) pflush_q <= pflush_q + 32'd1;
        end
    end

    assign perf_data_stalls = pdata_q;
    assign perf_ctrl_stalls = pctrl_q;
    assign perf_flushes     = pflush_q;
`endif

endmodule
